// File: rtl/hxd32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hxd32_pkg
// Brief    : Shared defaults and the fetch queue entry type for the HXD32 IFU.
// Revision : 1.0 - initial release
// ============================================================================
package hxd32_pkg;

    localparam int                        DEFAULT_XLEN     = 32;
    localparam int                        INST_BYTES       = 4;
    localparam logic [DEFAULT_XLEN-1:0]   DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [DEFAULT_XLEN-1:0] pc;
        logic [DEFAULT_XLEN-1:0] inst;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/ifu_prefetch_if.sv
`default_nettype none
// ============================================================================
// Module   : ifu_prefetch_if
// Brief    : IRAM read port and decode-side instruction handshake of the IFU.
// Revision : 1.0 - initial release
// ============================================================================
interface ifu_prefetch_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH + 1);

    logic            iram_rd_en;
    logic [XLEN-1:0] iram_rd_addr;
    logic [XLEN-1:0] iram_rd_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    logic [XLEN-1:0] inst_pc_next;
    logic [LW-1:0]   level;

    // master is the fetch unit; slave is the IRAM + decode environment
    modport master (
        output iram_rd_en, iram_rd_addr,
        input  iram_rd_data,
        output inst_valid, inst_data, inst_pc, inst_pc_next, level,
        input  inst_ready
    );

    modport slave (
        input  iram_rd_en, iram_rd_addr,
        output iram_rd_data,
        input  inst_valid, inst_data, inst_pc, inst_pc_next, level,
        output inst_ready
    );

endinterface
`default_nettype wire

// File: rtl/ifu_prefetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : DEPTH-entry synchronous FIFO of fetch entries; flush beats push/pop.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import hxd32_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       push,
    input  wire logic                       pop,
    input  wire logic                       flush,
    input  wire entry_t                     wr_entry,
    output entry_t                          head,
    output logic [$clog2(DEPTH+1)-1:0]      level,
    output logic                            empty
);

    localparam int              PW      = $clog2(DEPTH);
    localparam int              LW      = $clog2(DEPTH + 1);
    localparam logic [LW-1:0]   DEPTH_L = LW'(DEPTH);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            full;
    logic            do_push;
    logic            do_pop;

    assign empty   = (level == '0);
    assign full    = (level == DEPTH_L);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: head contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wr_entry;
    end

endmodule
`default_nettype wire

// File: rtl/ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_prefetch
// Brief    : Sequential IRAM prefetcher with instruction queue and redirect.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_prefetch
    import hxd32_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  wire logic            clk_i,
    input  wire logic            rst_i,
    input  wire logic            redirect_en_i,
    input  wire logic [XLEN-1:0] redirect_pc_i,
    ifu_prefetch_if.master       bus
);

    localparam int             LW      = $clog2(DEPTH + 1);
    localparam logic [LW:0]    DEPTH_W = (LW + 1)'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic            inflight;
    logic            issue;
    logic            push;
    logic            pop;
    logic [LW-1:0]   level;
    logic            empty;
    logic [LW:0]     committed;
    entry_t          wr_entry;
    entry_t          head;

    // Slots already spoken for: queued entries plus the read still in flight.
    assign committed = {1'b0, level} + {{LW{1'b0}}, inflight};
    assign issue     = !rst_i && !redirect_en_i && (committed < DEPTH_W);

    // Issue is blocked during a redirect, so clearing inflight squashes it.
    assign push      = inflight && !redirect_en_i;
    assign pop       = !empty && bus.inst_ready && !redirect_en_i;
    assign wr_entry  = '{pc: req_pc, inst: bus.iram_rd_data};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else if (redirect_en_i) begin
            fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + XLEN'(INST_BYTES);
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (push),
        .pop      (pop),
        .flush    (redirect_en_i),
        .wr_entry (wr_entry),
        .head     (head),
        .level    (level),
        .empty    (empty)
    );

    assign bus.iram_rd_en   = issue;
    assign bus.iram_rd_addr = fetch_pc;
    assign bus.inst_valid   = !empty;
    assign bus.inst_data    = head.inst;
    assign bus.inst_pc      = head.pc;
    assign bus.inst_pc_next = head.pc + XLEN'(INST_BYTES);
    assign bus.level        = level;

endmodule
`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_prefetch
// Brief    : Self-checking bench for ifu_prefetch (DEPTH = 4, RESET_PC = 0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_prefetch;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] iram_data;
    int          checks;
    int          errors;

    ifu_prefetch_if #(.XLEN(32), .DEPTH(DEPTH)) bus ();

    ifu_prefetch #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .redirect_en_i (redir),
        .redirect_pc_i (rpc),
        .bus           (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // IRAM: one-cycle latency; junk when no read was issued
    always @(posedge clk) iram_data <= bus.iram_rd_en ? mem_word(bus.iram_rd_addr) : $urandom;
    assign bus.iram_rd_data = iram_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        en;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [2:0]  level;
    } vec_t;

    vec_t vq[$];

    // Reference model state: queued PCs, fetch PC and the pending read.
    logic [31:0] mq[$];
    logic [31:0] m_fpc;
    logic        m_pend;
    logic [31:0] m_pend_pc;

    task automatic model_cycle(input int cyc);
        logic exp_en;
        string s;
        s = $sformatf("rnd%0d", cyc);
        exp_en = !redir && ((mq.size() + int'(m_pend)) < DEPTH);
        check({s, "_en"},    32'(bus.iram_rd_en), 32'(exp_en));
        check({s, "_addr"},  bus.iram_rd_addr, m_fpc);
        check({s, "_valid"}, 32'(bus.inst_valid), 32'(mq.size() != 0));
        check({s, "_level"}, 32'(bus.level), 32'(mq.size()));
        if (mq.size() != 0) begin
            check({s, "_pc"},   bus.inst_pc, mq[0]);
            check({s, "_data"}, bus.inst_data, mem_word(mq[0]));
            check({s, "_next"}, bus.inst_pc_next, mq[0] + 32'd4);
        end
        if (m_pend)
            check({s, "_push_full"}, 32'(mq.size() == DEPTH && !bus.inst_ready), 32'd0);
        if (redir) begin
            mq.delete();
            m_fpc  = {rpc[31:2], 2'b00};
            m_pend = 1'b0;
        end else begin
            if (mq.size() != 0 && bus.inst_ready) void'(mq.pop_front());
            if (m_pend) mq.push_back(m_pend_pc);
            m_pend = exp_en;
            if (exp_en) begin
                m_pend_pc = m_fpc;
                m_fpc     = m_fpc + 32'd4;
            end
        end
    endtask

    initial begin
        int  waited;
        int  rdy_pct;
        logic hold;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        redir = 1'b0;
        rpc = '0;
        bus.inst_ready = 1'b0;

        //          ready redir rpc            en  addr           valid pc             level
        vq.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b0, 32'h0,          3'd0});
        vq.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0004, 1'b0, 32'h0,          3'd0});
        vq.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000,  3'd1});
        vq.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_000C, 1'b1, 32'h0000_0000,  3'd2});
        vq.push_back('{1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0010, 1'b1, 32'h0000_0000,  3'd3});
        vq.push_back('{1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0010, 1'b1, 32'h0000_0000,  3'd4});
        vq.push_back('{1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_0010, 1'b1, 32'h0000_0000,  3'd4});
        vq.push_back('{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0010, 1'b1, 32'h0000_0004,  3'd3});
        vq.push_back('{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0014, 1'b1, 32'h0000_0008,  3'd2});
        vq.push_back('{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0018, 1'b1, 32'h0000_000C,  3'd2});
        vq.push_back('{1'b1, 1'b1, 32'h103,      1'b0, 32'h0000_001C, 1'b1, 32'h0000_0010,  3'd2});
        vq.push_back('{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0100, 1'b0, 32'h0,          3'd0});
        vq.push_back('{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0104, 1'b0, 32'h0,          3'd0});
        vq.push_back('{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0108, 1'b1, 32'h0000_0100,  3'd1});
        vq.push_back('{1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0000_010C, 1'b1, 32'h0000_0104, 3'd1});
        vq.push_back('{1'b1, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,          3'd0});
        vq.push_back('{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b0, 32'h0,          3'd0});
        vq.push_back('{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC,  3'd1});
        vq.push_back('{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000,  3'd1});

        #2;
        check("reset_en",    32'(bus.iram_rd_en), 32'd0);
        check("reset_addr",  bus.iram_rd_addr, 32'h0);
        check("reset_valid", 32'(bus.inst_valid), 32'd0);
        check("reset_level", 32'(bus.level), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        foreach (vq[i]) begin
            bus.inst_ready = vq[i].ready;
            redir = vq[i].redir;
            rpc   = vq[i].rpc;
            #1;
            check($sformatf("vec%0d_en", i),    32'(bus.iram_rd_en), 32'(vq[i].en));
            check($sformatf("vec%0d_addr", i),  bus.iram_rd_addr, vq[i].addr);
            check($sformatf("vec%0d_valid", i), 32'(bus.inst_valid), 32'(vq[i].valid));
            check($sformatf("vec%0d_level", i), 32'(bus.level), 32'(vq[i].level));
            if (vq[i].valid) begin
                check($sformatf("vec%0d_pc", i),   bus.inst_pc, vq[i].pc);
                check($sformatf("vec%0d_data", i), bus.inst_data, mem_word(vq[i].pc));
                check($sformatf("vec%0d_next", i), bus.inst_pc_next, vq[i].pc + 32'd4);
            end
            @(negedge clk);
        end

        // Asynchronous reset mid-stream with three entries queued
        redir = 1'b0;
        bus.inst_ready = 1'b0;
        waited = 0;
        while (bus.level != 3'd3 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("fill_to_3_timeout", 32'(bus.level), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(bus.inst_valid), 32'd0);
        check("async_rst_en",    32'(bus.iram_rd_en), 32'd0);
        check("async_rst_level", 32'(bus.level), 32'd0);
        check("async_rst_addr",  bus.iram_rd_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Randomised traffic against the reference model
        mq.delete();
        m_fpc     = 32'h0;
        m_pend    = 1'b0;
        m_pend_pc = 32'h0;
        hold      = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rdy_pct = ((c / 200) % 2 == 1) ? 90 : 30;
            bus.inst_ready = ($urandom_range(0, 99) < rdy_pct);
            if (hold) redir = ($urandom_range(0, 99) < 40);
            else      redir = ($urandom_range(0, 99) < 5);
            hold = redir;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else                           rpc = $urandom;
            #1;
            model_cycle(c);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
